// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, handshake FSM states
// and the signed saturation bounds as functions of the datapath width.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_NEG = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Bit patterns of the largest / smallest signed value of width w (w <= 63).
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative signed multiplier: magnitudes are multiplied by shift-add, one bit per
// cycle for WIDTH cycles, then the product is presented with its sign applied.
module seq_mul_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cnt;
    logic               r_sign;
    logic               r_busy;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;

    // The most-negative operand's magnitude still fits as an unsigned WIDTH-bit value.
    assign w_mag_a = a[WIDTH-1] ? (-a) : a;
    assign w_mag_b = b[WIDTH-1] ? (-b) : b;
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_mcand <= w_mag_a;
            r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == CW'(WIDTH)) begin
                r_busy <= 1'b0;
            end else begin
                r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // After WIDTH steps the unit spends one cycle presenting the signed product.
    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == CW'(WIDTH));
    assign product = r_sign ? -$signed(r_acc) : $signed(r_acc);

endmodule

// File: rtl/seq_alu.sv
// Registered four-function signed ALU with valid/ready on both sides, optional
// saturation and an iterative multiplier; one operation in flight at a time.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

    state_t r_state, w_next;
    logic [WIDTH-1:0] r_result;
    logic r_ovf, r_zero, r_neg, r_out_valid;

    logic w_accept, w_start, w_load, w_valid_next;
    logic w_mul_busy, w_mul_done;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH:0] w_a_ext, w_b_ext, w_wide;
    logic w_ovf, w_exact_neg;
    logic [WIDTH-1:0] w_low, w_res;

    seq_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready; the sink
    // side may take the held result and the source side may refill on the same edge.
    assign in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_a_ext = {a[WIDTH-1], a};
    assign w_b_ext = {b[WIDTH-1], b};

    always_comb begin
        w_wide = '0;
        case (sel)
            OP_ADD:  w_wide = w_a_ext + w_b_ext;
            OP_SUB:  w_wide = w_a_ext - w_b_ext;
            OP_NEG:  w_wide = -w_b_ext;
            default: w_wide = '0;
        endcase
    end

    // While a multiply is running the result source is the multiplier product.
    always_comb begin
        if (r_state == MUL_BUSY) begin
            w_ovf       = (w_prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){w_prod[2*WIDTH-1]}});
            w_exact_neg = w_prod[2*WIDTH-1];
            w_low       = w_prod[WIDTH-1:0];
        end else begin
            w_ovf       = w_wide[WIDTH] ^ w_wide[WIDTH-1];
            w_exact_neg = w_wide[WIDTH];
            w_low       = w_wide[WIDTH-1:0];
        end
        w_res = (SATURATE != 0 && w_ovf) ? (w_exact_neg ? SMIN : SMAX) : w_low;
    end

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_valid_next = r_out_valid;
        case (r_state)
            IDLE, DONE: begin
                if (in_ready) begin
                    w_valid_next = 1'b0;
                    w_next       = IDLE;
                    if (in_valid) begin
                        if (sel == OP_MUL) begin
                            w_start = 1'b1;
                            w_next  = MUL_BUSY;
                        end else begin
                            w_load       = 1'b1;
                            w_valid_next = 1'b1;
                            w_next       = DONE;
                        end
                    end
                end
            end
            MUL_BUSY: begin
                if (w_mul_done) begin
                    w_load       = 1'b1;
                    w_valid_next = 1'b1;
                    w_next       = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_valid_next;
            if (w_load) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                r_zero   <= (w_res == '0);
                r_neg    <= w_res[WIDTH-1];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign busy      = w_mul_busy;
    assign dbg_state = r_state;

endmodule
